// File: rtl/ps2_pkg.sv
// Shared types and default timing for the PS/2 host transmitter.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} ps2_state_t;

  localparam int INHIBIT_CYCLES_DEF = 4000;
  localparam int START_CYCLES_DEF   = 80;
  localparam int TIMEOUT_CYCLES_DEF = 600000;
  localparam int FILTER_LEN_DEF     = 8;

  // Parity bit that makes {data, parity} carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       tx_timeout;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, tx_timeout);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, tx_timeout);
endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus glitch filter for one raw PS/2 line; idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is accepted only after FILTER_LEN consecutive samples of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int START_CYCLES   = START_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ps2_host_tx_if.slave     tx,
  input  logic             ps2_clk_in,
  input  logic             ps2_data_in,
  output logic             ps2_clk_oe,
  output logic             ps2_data_oe
);
  localparam int M1   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int TMAX = (TIMEOUT_CYCLES > M1) ? TIMEOUT_CYCLES : M1;
  localparam int TW   = $clog2(TMAX + 1);

  ps2_state_t    state, nxt;
  logic [9:0]    shift;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tmr;
  logic          ack_ok, dbit, clk_fq;
  logic [1:0]    line_in, line_f;

  assign line_in = {ps2_data_in, ps2_clk_in};

  for (genvar l = 0; l < 2; l++) begin : g_flt
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_flt (
      .clk(clk), .rst(rst), .din(line_in[l]), .dout(line_f[l])
    );
  end

  logic clk_f, dat_f, fall, lines_idle, tmo, inh_end, st_end;
  assign clk_f      = line_f[0];
  assign dat_f      = line_f[1];
  assign fall       = clk_fq & ~clk_f;
  assign lines_idle = clk_f & dat_f;
  assign inh_end    = (tmr == TW'(INHIBIT_CYCLES - 1));
  assign st_end     = (tmr == TW'(START_CYCLES - 1));
  // Timeout beats any edge arriving in the same cycle.
  assign tmo = (state inside {SEND, ACK, WAIT_IDLE}) && (tmr == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (tx.tx_valid) nxt = INHIBIT;
      INHIBIT:   if (inh_end) nxt = START;
      START:     if (st_end) nxt = SEND;
      SEND:      if (tmo) nxt = IDLE; else if (fall && bitcnt == 4'd9) nxt = ACK;
      ACK:       if (tmo) nxt = IDLE; else if (fall) nxt = WAIT_IDLE;
      WAIT_IDLE: if (tmo || lines_idle) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift  <= '0;
      bitcnt <= '0;
      tmr    <= '0;
      ack_ok <= 1'b0;
      dbit   <= 1'b0;
      clk_fq <= 1'b1;
    end else begin
      clk_fq <= clk_f;
      case (state)
        IDLE: begin
          tmr <= '0;
          if (tx.tx_valid) shift <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
        end
        INHIBIT: tmr <= inh_end ? '0 : tmr + TW'(1);
        START: begin
          tmr <= st_end ? '0 : tmr + TW'(1);
          if (st_end) begin
            bitcnt <= '0;
            dbit   <= 1'b1;
          end
        end
        SEND: begin
          tmr <= tmr + TW'(1);
          if (fall) begin
            dbit   <= ~shift[0];
            shift  <= {1'b0, shift[9:1]};
            bitcnt <= bitcnt + 4'd1;
          end
        end
        ACK: begin
          tmr <= tmr + TW'(1);
          if (fall) ack_ok <= ~dat_f;
        end
        WAIT_IDLE: tmr <= tmr + TW'(1);
        default: tmr <= '0;
      endcase
    end
  end

  always_comb begin
    tx.tx_ready   = 1'b0;
    tx.tx_done    = 1'b0;
    tx.tx_err     = 1'b0;
    tx.tx_timeout = tmo;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    case (state)
      IDLE:      tx.tx_ready = 1'b1;
      INHIBIT:   ps2_clk_oe  = 1'b1;
      START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      SEND, ACK: ps2_data_oe = dbit & ~tmo;
      WAIT_IDLE: if (!tmo && lines_idle) begin
        tx.tx_done = ack_ok;
        tx.tx_err  = ~ack_ok;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 4000: clock-low inhibit time in clk cycles (100 us at 40 MHz).
REQ-002 Parameter START_CYCLES, default 80: time data is driven low before the clock is released (2 us).
REQ-003 Parameter TIMEOUT_CYCLES, default 600000: maximum cycles from clock release to completion (15 ms).
REQ-004 Parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a PS/2 line change.
REQ-005 One clock and one asynchronous, active-low reset: clk  in  1  system clock (40 MHz); rst  in  1  asynchronous, active-low reset.
REQ-006 tx_data  in  8  command byte to send to the device.
REQ-007 tx_valid  in  1  request to send; tx_ready  out  1  high when the block can accept a byte.
REQ-008 tx_done  out  1  one-cycle pulse when the device has acknowledged the byte.
REQ-009 tx_err  out  1  one-cycle pulse when the ACK bit was sampled high.
REQ-010 tx_timeout  out  1  one-cycle pulse when the transfer was aborted after TIMEOUT_CYCLES.
REQ-011 ps2_clk_in / ps2_data_in  in  1  raw, asynchronous PS/2 line levels.
REQ-012 ps2_clk_oe / ps2_data_oe  out  1  1 = pull the line low, 0 = release it (the top level builds the open-drain tristate).

Function
REQ-013 Both PS/2 inputs SHALL pass through a 2-FF synchronizer and a FILTER_LEN glitch filter; falling edges SHALL be detected on the filtered clock.
REQ-014 FSM states: IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-015 IDLE: tx_ready=1, both oe=0; on tx_valid&&tx_ready, latch {stop=1, odd parity, tx_data} into a 10-bit shift register and go to INHIBIT.
REQ-016 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-017 START: clk_oe=1, data_oe=1 for exactly START_CYCLES cycles; then clk_oe=0, data_oe=1 (start bit), clear the bit counter and the timeout counter, go to SEND.
REQ-018 SEND: on each filtered falling edge, set data_oe = ~shift[0], shift right, and increment the bit counter (data LSB first, then parity, then stop with data_oe=0).
REQ-019 After the stop bit has been presented (10th falling edge), go to ACK.
REQ-020 ACK: on the 11th falling edge, sample filtered data: low -> go to WAIT_IDLE with the ACK flagged OK; high -> flagged error.
REQ-021 WAIT_IDLE: when filtered clk and data are both high, pulse tx_done (OK) or tx_err (error) and return to IDLE.
REQ-022 The parity bit SHALL make the number of ones in {data, parity} odd.
REQ-023 The timeout counter runs in SEND, ACK and WAIT_IDLE; on reaching TIMEOUT_CYCLES, release both lines, pulse tx_timeout, and go to IDLE (this takes priority over a simultaneous edge).
REQ-024 tx_valid outside IDLE SHALL be ignored; tx_data SHALL be sampled only at acceptance.
REQ-025 At most one of tx_done, tx_err, tx_timeout SHALL pulse per transfer.

Reset
REQ-026 While rst=0: state=IDLE, all counters 0, ps2_clk_oe=0, ps2_data_oe=0, tx_done=tx_err=tx_timeout=0, tx_ready=1, and the synchronizer/filter outputs are 1.
REQ-027 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously) and produce no completion pulse.

Structure
REQ-028 Package ps2_pkg holds the FSM state enum and the default timing constants.
REQ-029 The synchronizer and glitch filter form a sub-module, ps2_line_filter, instantiated once per line.

Verification
REQ-030 Send 0xF4 with a device model clocking at 12.5 kHz and ACKing -> device receives bits 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once.
REQ-031 Send 0xFF -> parity bit 1; clk_oe low for exactly 4000 cycles, data_oe high 80 cycles before clk release.
REQ-032 Device leaves data high on the 11th clock -> tx_err pulses once, no tx_done.
REQ-033 Device never clocks -> tx_timeout pulses 600000 cycles after clock release, both oe=0, tx_ready=1.
REQ-034 rst low during bit 4 -> both oe=0 in the same cycle; no pulses; a transfer after reset completes normally.
REQ-035 tx_valid pulsed during SEND with 0x00 -> ignored; the byte in flight is unchanged; 2-cycle glitches on ps2_clk_in create no extra bits.
